// File: rtl/csync_separator.sv
// Splits active-low composite sync into hsync, vsync and a frame marker
// by classifying low/high run lengths of the synchronized input.
module csync_separator #(
  parameter int CNT_W    = 8,
  parameter int V_THRESH = 16,
  parameter int V_EXIT   = 16,
  parameter int HS_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic csync,
  output logic hsync,
  output logic vsync,
  output logic frame_start
);

  localparam int HW = (HS_WIDTH < 2) ? 1 : $clog2(HS_WIDTH + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TH      = CNT_W'(V_THRESH);
  localparam logic [CNT_W-1:0] EX      = CNT_W'(V_EXIT);
  localparam logic [HW-1:0]    HS_LD   = HW'(HS_WIDTH);
  localparam logic [HW-1:0]    HS_ONE  = HW'(1);

  typedef enum logic {
    LINE,
    VSYNC
  } state_t;

  state_t           state;
  logic             s0, s1, s2;
  logic [CNT_W-1:0] run_cnt, run_nxt;
  logic [HW-1:0]    hs_cnt, hs_nxt;
  logic             fall, rise;
  logic             trig, enter, leave;

  // run_nxt is the length of the current run including this cycle
  always_comb begin
    fall    = s2 & ~s1;
    rise    = ~s2 & s1;
    run_nxt = run_cnt;
    if (fall | rise)
      run_nxt = CNT_ONE;
    else if (run_cnt != CNT_MAX)
      run_nxt = run_cnt + CNT_ONE;
    enter = (state == LINE) && !s1 && (run_nxt == TH);
    leave = (state == VSYNC) && s1 && (run_nxt == EX);
    trig  = (state == LINE) ? fall : rise;
    hs_nxt = '0;
    if (trig)
      hs_nxt = HS_LD;
    else if (hs_cnt != '0)
      hs_nxt = hs_cnt - HS_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0          <= 1'b1;
      s1          <= 1'b1;
      s2          <= 1'b1;
      run_cnt     <= '0;
      hs_cnt      <= '0;
      state       <= LINE;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      s0          <= csync;
      s1          <= s0;
      s2          <= s1;
      run_cnt     <= run_nxt;
      hs_cnt      <= hs_nxt;
      hsync       <= (hs_nxt == '0);
      frame_start <= enter;
      if (enter) begin
        state <= VSYNC;
        vsync <= 1'b0;
      end else if (leave) begin
        state <= LINE;
        vsync <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csync_separator.sv
// Directed vector bench for csync_separator with default parameters.
module tb_csync_separator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic csync = 1'b0;
  logic hsync, vsync, frame_start;

  csync_separator dut (
    .clk(clk),
    .rst(rst),
    .csync(csync),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int exp_pulses;
    int exp_hs_low;
    int exp_vs_at;
    int exp_vs_low;
    int exp_vs_rise;
  } vec_t;

  vec_t vecs[5];

  int total = 0;
  int passed = 0;

  int cyc;
  int hs_low, hs_pulses, hs_first;
  int vs_low, vs_first, vs_rise;
  int fs_cnt, fs_first;
  logic prev_hs, prev_vs;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clr();
    cyc = -1;
    hs_low = 0; hs_pulses = 0; hs_first = -1;
    vs_low = 0; vs_first = -1; vs_rise = -1;
    fs_cnt = 0; fs_first = -1;
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!hsync) begin
      hs_low++;
      if (hs_first < 0) hs_first = cyc;
      if (prev_hs) hs_pulses++;
    end
    if (!vsync) begin
      vs_low++;
      if (vs_first < 0) vs_first = cyc;
    end
    if (vsync && !prev_vs && vs_rise < 0) vs_rise = cyc;
    if (frame_start) begin
      fs_cnt++;
      if (fs_first < 0) fs_first = cyc;
    end
    prev_hs = hsync;
    prev_vs = vsync;
  endtask

  task automatic idle();
    csync = 1'b1;
    repeat (40) step();
  endtask

  int p0, rc;

  initial begin
    vecs[0] = '{1,  1, 4, -1, 0,  -1};
    vecs[1] = '{2,  1, 4, -1, 0,  -1};
    vecs[2] = '{15, 1, 4, -1, 0,  -1};
    vecs[3] = '{16, 2, 8, 17, 16, 33};
    vecs[4] = '{40, 2, 8, 17, 40, 57};

    // reset held with csync low
    clr();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_outs", int'({hsync, vsync, frame_start}), 3'b110);
    end
    rst = 1'b0;
    clr();
    for (int i = 0; i < 25; i++) begin
      step();
      if (cyc == 2) csync = 1'b1;
    end
    chk("post_rst_hs_first", hs_first, 2);
    chk("post_rst_hs_low", hs_low, 4);
    chk("post_rst_vs", vs_first, -1);
    chk("post_rst_fs", fs_cnt, 0);

    // table: one low run of len cycles from idle
    foreach (vecs[v]) begin
      idle();
      clr();
      csync = 1'b0;
      for (int i = 0; i < vecs[v].len + 40; i++) begin
        step();
        if (cyc == vecs[v].len - 1) csync = 1'b1;
      end
      chk($sformatf("v%0d_hs_first", v), hs_first, 2);
      chk($sformatf("v%0d_pulses", v), hs_pulses, vecs[v].exp_pulses);
      chk($sformatf("v%0d_hs_low", v), hs_low, vecs[v].exp_hs_low);
      chk($sformatf("v%0d_vs_at", v), vs_first, vecs[v].exp_vs_at);
      chk($sformatf("v%0d_fs_at", v), fs_first, vecs[v].exp_vs_at);
      chk($sformatf("v%0d_fs_cnt", v), fs_cnt, (vecs[v].exp_vs_at < 0) ? 0 : 1);
      chk($sformatf("v%0d_vs_low", v), vs_low, vecs[v].exp_vs_low);
      chk($sformatf("v%0d_vs_rise", v), vs_rise, vecs[v].exp_vs_rise);
    end

    // retrigger: falls at k and k+2
    idle();
    clr();
    csync = 1'b0; step();
    csync = 1'b1; step();
    csync = 1'b0; step();
    csync = 1'b1;
    repeat (20) step();
    chk("retrig_first", hs_first, 2);
    chk("retrig_low", hs_low, 6);
    chk("retrig_pulses", hs_pulses, 1);
    chk("retrig_fs", fs_cnt, 0);

    // serrated vertical sync
    idle();
    clr();
    csync = 1'b0;
    repeat (20) step();
    chk("serr_vs_in", int'(vsync), 0);
    for (int b = 0; b < 3; b++) begin
      repeat (227) step();
      p0 = hs_pulses;
      csync = 1'b1; step();
      csync = 1'b0; step();
      chk($sformatf("serr%0d_hs_b1", b), int'(hsync), 1);
      step();
      chk($sformatf("serr%0d_hs_b2", b), int'(hsync), 0);
      repeat (10) step();
      chk($sformatf("serr%0d_pulse", b), hs_pulses, p0 + 1);
      chk($sformatf("serr%0d_vs", b), int'(vsync), 0);
    end
    repeat (20) step();
    p0 = hs_pulses;
    csync = 1'b1; step();
    rc = cyc;
    repeat (30) step();
    chk("serr_exit_at", vs_rise - rc, 17);
    chk("serr_exit_pulse", hs_pulses, p0 + 1);
    chk("serr_total_pulses", hs_pulses, 5);
    chk("serr_fs", fs_cnt, 1);

    // saturation with long low run
    idle();
    clr();
    csync = 1'b0;
    repeat (1000) step();
    chk("sat_fs", fs_cnt, 1);
    chk("sat_vs", int'(vsync), 0);
    chk("sat_vs_low", vs_low, 983);
    chk("sat_pulses", hs_pulses, 1);
    csync = 1'b1;
    repeat (30) step();
    chk("sat_exit", int'(vsync), 1);

    // reset while hsync and vsync are both low
    idle();
    clr();
    csync = 1'b0;
    repeat (20) step();
    csync = 1'b1;
    repeat (3) step();
    chk("mid_pre", int'({hsync, vsync}), 2'b00);
    rst = 1'b1;
    step();
    chk("mid_rst", int'({hsync, vsync, frame_start}), 3'b110);
    rst = 1'b0;
    idle();
    clr();
    csync = 1'b0;
    repeat (2) step();
    csync = 1'b1;
    repeat (40) step();
    chk("mid_hs_low", hs_low, 4);
    chk("mid_hs_first", hs_first, 2);
    chk("mid_vs", vs_first, -1);
    chk("mid_fs", fs_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
